// File: rtl/treasure_vote_filter.sv
// rtl/treasure_vote_filter.sv - frame-to-frame vote filter for the treasure classifier code
//
// Ports:
//   CLK           in   system clock
//   RESET_N       in   asynchronous active-low reset
//   CODE_IN       in   per-frame classifier code {colour, shape[1:0]}
//   CODE_VALID    in   one-cycle strobe qualifying CODE_IN
//   CODE_OUT      out  debounced code
//   CODE_STABLE   out  last decision met THRESH
//   CODE_CHANGED  out  one-cycle pulse when CODE_OUT changes
//   STALE         out  no frame seen for TIMEOUT_CYCLES
module treasure_vote_filter #(
    parameter int DEPTH          = 8,
    parameter int THRESH         = 5,
    parameter int TIMEOUT_CYCLES = 5_000_000
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [2:0] CODE_IN,
    input  logic       CODE_VALID,
    output logic [2:0] CODE_OUT,
    output logic       CODE_STABLE,
    output logic       CODE_CHANGED,
    output logic       STALE
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        DECIDE = 2'd2
    } state_t;

    state_t             state_q;
    logic [2:0]         hist_code_q [DEPTH];
    logic [DEPTH-1:0]   hist_vld_q;
    logic               pend_q;
    logic [2:0]         pend_code_q;
    logic [2:0]         cand_q;
    logic [IDX_W-1:0]   idx_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [TMO_W-1:0]   tmo_q;
    logic [TMO_W-1:0]   tmo_d;
    logic [2:0]         out_q;
    logic               stable_q;
    logic               changed_q;
    logic               stale_q;

    logic [2:0]         in_norm;
    logic [2:0]         start_code;
    logic               start;
    logic               tmo_hit;
    logic               match;

    always_comb begin
        // No shape detected means no treasure; colour bit is meaningless then.
        in_norm    = (CODE_IN[1:0] == 2'b00) ? 3'b000 : CODE_IN;
        start      = CODE_VALID || pend_q;
        start_code = CODE_VALID ? in_norm : pend_code_q;
        // Fires only on the step into the saturated value, so it cannot repeat.
        tmo_hit    = !CODE_VALID && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
        if (CODE_VALID) begin
            tmo_d = '0;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES)) begin
            tmo_d = tmo_q;
        end else begin
            tmo_d = tmo_q + TMO_W'(1);
        end
        match = hist_vld_q[idx_q] && (hist_code_q[idx_q] == cand_q);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            for (int i = 0; i < DEPTH; i++) begin
                hist_code_q[i] <= 3'b000;
            end
            hist_vld_q  <= '0;
            pend_q      <= 1'b0;
            pend_code_q <= 3'b000;
            cand_q      <= 3'b000;
            idx_q       <= '0;
            cnt_q       <= '0;
            tmo_q       <= '0;
            out_q       <= 3'b000;
            stable_q    <= 1'b0;
            changed_q   <= 1'b0;
            stale_q     <= 1'b0;
        end else begin
            tmo_q     <= tmo_d;
            changed_q <= 1'b0;
            if (CODE_VALID) begin
                stale_q <= 1'b0;
            end

            if (tmo_hit) begin
                // Timeout overrides any scan in flight and forgets all history.
                stale_q    <= 1'b1;
                out_q      <= 3'b000;
                stable_q   <= 1'b0;
                changed_q  <= (out_q != 3'b000);
                hist_vld_q <= '0;
                pend_q     <= 1'b0;
                state_q    <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            for (int i = DEPTH - 1; i > 0; i--) begin
                                hist_code_q[i] <= hist_code_q[i-1];
                            end
                            hist_code_q[0] <= start_code;
                            hist_vld_q     <= {hist_vld_q[DEPTH-2:0], 1'b1};
                            cand_q         <= start_code;
                            idx_q          <= '0;
                            cnt_q          <= '0;
                            pend_q         <= 1'b0;
                            state_q        <= SCAN;
                        end
                    end
                    SCAN: begin
                        if (CODE_VALID) begin
                            pend_q      <= 1'b1;
                            pend_code_q <= in_norm;
                        end
                        cnt_q <= cnt_q + CNT_W'(match);
                        idx_q <= idx_q + IDX_W'(1);
                        if (idx_q == IDX_W'(DEPTH - 1)) begin
                            state_q <= DECIDE;
                        end
                    end
                    DECIDE: begin
                        if (CODE_VALID) begin
                            pend_q      <= 1'b1;
                            pend_code_q <= in_norm;
                        end
                        if (cnt_q >= CNT_W'(THRESH)) begin
                            stable_q  <= 1'b1;
                            out_q     <= cand_q;
                            changed_q <= (cand_q != out_q);
                        end else begin
                            stable_q  <= 1'b0;
                        end
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign CODE_OUT     = out_q;
    assign CODE_STABLE  = stable_q;
    assign CODE_CHANGED = changed_q;
    assign STALE        = stale_q;

endmodule

// File: tb/tb_treasure_vote_filter.sv
// tb/tb_treasure_vote_filter.sv - directed self-checking bench for treasure_vote_filter
module tb_treasure_vote_filter;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic [2:0] CODE_IN = 3'b000;
    logic       CODE_VALID = 1'b0;
    logic [2:0] CODE_OUT;
    logic       CODE_STABLE;
    logic       CODE_CHANGED;
    logic       STALE;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int e0 = 0;
    int chg_cnt = 0;
    int last_chg_cyc = -1;
    int consec = 0;
    logic prev_chg = 1'b0;
    int base;

    treasure_vote_filter #(
        .DEPTH(8),
        .THRESH(5),
        .TIMEOUT_CYCLES(1000)
    ) dut (
        .CLK(CLK),
        .RESET_N(RESET_N),
        .CODE_IN(CODE_IN),
        .CODE_VALID(CODE_VALID),
        .CODE_OUT(CODE_OUT),
        .CODE_STABLE(CODE_STABLE),
        .CODE_CHANGED(CODE_CHANGED),
        .STALE(STALE)
    );

    always #10 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(posedge CLK) begin
        #1;
        if (CODE_CHANGED) begin
            chg_cnt = chg_cnt + 1;
            last_chg_cyc = cyc;
        end
        if (CODE_CHANGED && prev_chg) consec = consec + 1;
        prev_chg = CODE_CHANGED;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET_N = 1'b0;
        CODE_VALID = 1'b0;
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
    endtask

    task automatic frame(input logic [2:0] c, input int gap);
        @(negedge CLK);
        CODE_IN = c;
        CODE_VALID = 1'b1;
        @(posedge CLK);
        #1;
        e0 = cyc;
        @(negedge CLK);
        CODE_VALID = 1'b0;
        repeat (gap - 1) @(negedge CLK);
    endtask

    task automatic expect_out(input string tag, input logic [2:0] o, input logic s, input int dchg);
        check({tag, "_out"}, 32'(CODE_OUT), 32'(o));
        check({tag, "_stable"}, 32'(CODE_STABLE), 32'(s));
        check({tag, "_chg"}, 32'(chg_cnt - base), 32'(dchg));
        base = chg_cnt;
    endtask

    initial begin
        // Test 1: reset values, then asynchronous reset in the middle of a scan
        do_reset();
        base = chg_cnt;
        check("rst_out", 32'(CODE_OUT), 32'h0);
        check("rst_stable", 32'(CODE_STABLE), 32'h0);
        check("rst_stale", 32'(STALE), 32'h0);
        for (int i = 0; i < 8; i++) frame(3'b110, 20);
        expect_out("t1_fill", 3'b110, 1'b1, 1);
        @(negedge CLK);
        CODE_IN = 3'b110;
        CODE_VALID = 1'b1;
        @(negedge CLK);
        CODE_VALID = 1'b0;
        repeat (3) @(negedge CLK);
        RESET_N = 1'b0;
        #1;
        check("t1_async_out", 32'(CODE_OUT), 32'h0);
        check("t1_async_stable", 32'(CODE_STABLE), 32'h0);
        check("t1_async_chg", 32'(CODE_CHANGED), 32'h0);
        check("t1_async_stale", 32'(STALE), 32'h0);
        @(negedge CLK);
        RESET_N = 1'b1;
        base = chg_cnt;
        frame(3'b110, 20);
        expect_out("t1_after", 3'b000, 1'b0, 0);

        // Test 3: alternating codes never reach the threshold
        do_reset();
        base = chg_cnt;
        for (int i = 0; i < 8; i++) frame((i % 2 == 0) ? 3'b101 : 3'b011, 30);
        expect_out("t3", 3'b000, 1'b0, 0);

        // Test 2: five identical frames from reset
        do_reset();
        base = chg_cnt;
        for (int i = 1; i <= 4; i++) begin
            frame(3'b110, 200);
            expect_out($sformatf("t2_f%0d", i), 3'b000, 1'b0, 0);
        end
        frame(3'b110, 200);
        check("t2_chg_lat", 32'(last_chg_cyc - e0), 32'd9);
        expect_out("t2_f5", 3'b110, 1'b1, 1);

        // Test 4: shape 00 normalises to 000 and takes over on the 5th frame
        for (int i = 1; i <= 8; i++) begin
            frame(3'b100, 200);
            if (i < 5)       expect_out($sformatf("t4_f%0d", i), 3'b110, 1'b0, 0);
            else if (i == 5) expect_out("t4_f5", 3'b000, 1'b1, 1);
            else             expect_out($sformatf("t4_f%0d", i), 3'b000, 1'b1, 0);
        end

        // Test 6: second strobe during scan waits in the pending register
        for (int i = 0; i < 5; i++) frame(3'b010, 200);
        expect_out("t6_pre", 3'b010, 1'b1, 1);
        @(negedge CLK);
        CODE_IN = 3'b010;
        CODE_VALID = 1'b1;
        @(posedge CLK);
        #1;
        e0 = cyc;
        @(negedge CLK);
        CODE_VALID = 1'b0;
        @(negedge CLK);
        CODE_IN = 3'b011;
        CODE_VALID = 1'b1;
        @(negedge CLK);
        CODE_VALID = 1'b0;
        while (cyc < e0 + 12) @(negedge CLK);
        check("t6_first_decide_stable", 32'(CODE_STABLE), 32'h1);
        while (cyc < e0 + 22) @(negedge CLK);
        check("t6_hist0", 32'(dut.hist_code_q[0]), 32'(3'b011));
        check("t6_hist1", 32'(dut.hist_code_q[1]), 32'(3'b010));
        expect_out("t6_post", 3'b010, 1'b0, 0);

        // Test 5: timeout forces 000 once, then recovery needs a full vote
        for (int i = 0; i < 5; i++) frame(3'b111, 200);
        expect_out("t5_pre", 3'b111, 1'b1, 1);
        begin
            int found = 0;
            int stale_cyc = 0;
            for (int k = 0; k < 1500 && found == 0; k++) begin
                @(posedge CLK);
                #1;
                if (STALE) begin
                    found = 1;
                    stale_cyc = cyc;
                end
            end
            check("t5_stale_seen", 32'(found), 32'd1);
            check("t5_stale_lat", 32'(stale_cyc - e0), 32'd1000);
        end
        @(negedge CLK);
        expect_out("t5_timeout", 3'b000, 1'b0, 1);
        repeat (1500) @(negedge CLK);
        check("t5_still_stale", 32'(STALE), 32'h1);
        expect_out("t5_quiet", 3'b000, 1'b0, 0);
        frame(3'b111, 200);
        check("t5_stale_clr", 32'(STALE), 32'h0);
        for (int i = 2; i <= 4; i++) frame(3'b111, 200);
        expect_out("t5_f4", 3'b000, 1'b0, 0);
        frame(3'b111, 200);
        expect_out("t5_f5", 3'b111, 1'b1, 1);

        check("no_consec_chg", 32'(consec), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
